// File: rtl/control_sequencer.sv
// SAP control sequencer: IR, negedge T-state counter, halt latch, ucode ROM addressing.
// Optional CTRL_SEQ_VARLEN_EN: honour the microcode end flag from T2 onward.
module control_sequencer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OP_W       = 4,
  parameter int unsigned T_W        = 3,
  parameter int unsigned T_STATES   = 6,
  parameter int unsigned CW_W       = 18,
  parameter int unsigned IR_IN_BIT  = 10,
  parameter int unsigned IR_OUT_BIT = 9,
  parameter int unsigned HALT_BIT   = 17
) (
  input  logic                  clk,
  input  logic                  cls,
  input  logic [DATA_W-1:0]     BUS,
  input  logic [CW_W:0]         ucode_q,
  output logic [OP_W+T_W-1:0]   ucode_addr,
  output logic [CW_W-1:0]       ctrl,
  output logic [DATA_W-1:0]     i_reg,
  output logic [DATA_W-1:0]     operand,
  output logic [T_W-1:0]        tstate,
  output logic                  halted
);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [T_W-1:0] T_LAST  = T_W'(T_STATES - 1);
  localparam logic [T_W-1:0] T_FIRST = T_W'(2);

  state_t              state_q, state_d;
  logic [T_W-1:0]      tstate_q, tstate_d;
  logic [DATA_W-1:0]   i_reg_q, i_reg_d;
  logic                end_ok;

  // end flag only counts once past the shared fetch states
`ifdef CTRL_SEQ_VARLEN_EN
  assign end_ok = ucode_q[CW_W] && (tstate_q >= T_FIRST);
`else
  logic unused_end_flag;
  assign unused_end_flag = ucode_q[CW_W];
  assign end_ok = 1'b0;
`endif

  // control word is gated off while halted or held in reset
  always_comb begin
    ctrl = ucode_q[CW_W-1:0];
    if (cls || (state_q == S_HALT)) begin
      ctrl = '0;
    end
  end

  // IR next value: load from the bus when the control word asks for it
  always_comb begin
    i_reg_d = i_reg_q;
    if (ctrl[IR_IN_BIT]) begin
      i_reg_d = BUS;
    end
  end

  // IR register, datapath transfers happen on the rising edge
  always_ff @(posedge clk or posedge cls) begin
    if (cls) begin
      i_reg_q <= '0;
    end else begin
      i_reg_q <= i_reg_d;
    end
  end

  // next T-state and halt; halt wins over wrap and end flag
  always_comb begin
    state_d  = state_q;
    tstate_d = tstate_q;
    unique case (state_q)
      S_RUN: begin
        if (ctrl[HALT_BIT]) begin
          state_d = S_HALT;
        end else if (tstate_q == T_LAST) begin
          tstate_d = '0;
        end else if (end_ok) begin
          tstate_d = '0;
        end else begin
          tstate_d = tstate_q + T_W'(1);
        end
      end
      S_HALT: begin
        state_d  = S_HALT;
        tstate_d = tstate_q;
      end
    endcase
  end

  // T-state counter and halt latch advance on the falling edge
  always_ff @(negedge clk or posedge cls) begin
    if (cls) begin
      state_q  <= S_RUN;
      tstate_q <= '0;
    end else begin
      state_q  <= state_d;
      tstate_q <= tstate_d;
    end
  end

  // operand field is driven only when the IR output bit is active
  always_comb begin
    operand = '0;
    if (ctrl[IR_OUT_BIT]) begin
      operand = {{OP_W{1'b0}}, i_reg_q[DATA_W-OP_W-1:0]};
    end
  end

  assign ucode_addr = {i_reg_q[DATA_W-1 -: OP_W], tstate_q};
  assign i_reg      = i_reg_q;
  assign tstate     = tstate_q;
  assign halted     = (state_q == S_HALT);

endmodule
